// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into SHORT / LONG / DOUBLE events on a valid/ready output.
// Optional macro AUTO_REPEAT_EN adds periodic REPEAT events while a LONG press is held.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 16,
  parameter int DCLICK_CYCLES = 8,
  parameter int REPEAT_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clean_in,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow,
  output logic       busy
);

  localparam int MAX_AB = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_CNT = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CNT + 1);

  localparam logic [1:0] CODE_REPEAT = 2'b00;
  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_DOUBLE = 2'b11;

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT_SECOND,
    SECOND_PRESSED,
    LONG_HELD
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          emit;
  logic [1:0]    emit_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_code  = CODE_REPEAT;
    unique case (state)
      IDLE: begin
        if (clean_in) begin
          state_next = PRESSED;
          cnt_next   = CW'(1);
        end
      end
      PRESSED: begin
        if (clean_in) begin
          if (cnt == LONG_LAST) begin
            emit       = 1'b1;
            emit_code  = CODE_LONG;
            state_next = LONG_HELD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          state_next = WAIT_SECOND;
          cnt_next   = CW'(1);
        end
      end
      WAIT_SECOND: begin
        if (clean_in) begin
          state_next = SECOND_PRESSED;
        end else if (cnt == DCLICK_LAST) begin
          emit       = 1'b1;
          emit_code  = CODE_SHORT;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      SECOND_PRESSED: begin
        // The second press is never timed, so it can be held indefinitely.
        if (!clean_in) begin
          emit       = 1'b1;
          emit_code  = CODE_DOUBLE;
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      LONG_HELD: begin
        if (!clean_in) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
          emit      = 1'b1;
          emit_code = CODE_REPEAT;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output slot: a new event loads only if the slot is empty or being drained this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid    <= 1'b0;
      evt_code     <= 2'b00;
      evt_overflow <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (emit) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= emit_code;
        end else begin
          evt_overflow <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
